// File: rtl/parity_accumulator.sv
// Packet longitudinal-check accumulator: XORs every accepted word of a packet,
// counts the words (saturating) and presents LRC, parity and count until consumed.
module parity_accumulator #(
  parameter int W   = 8,
  parameter bit ODD = 1'b0,
  parameter int CW  = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_data,
  input  logic          in_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_lrc,
  output logic          out_parity,
  output logic [CW-1:0] out_count,
  output logic          out_sat
);

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  localparam logic [CW-1:0] CNT_MAX = '1;

  state_t        state;
  logic [W-1:0]  lrc_acc;
  logic [CW-1:0] cnt;
  logic          sat;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
    return (c == CNT_MAX) ? c : c + CW'(1);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ACCUM;
      lrc_acc <= '0;
      cnt     <= '0;
      sat     <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (in_valid) begin
            lrc_acc <= lrc_acc ^ in_data;
            cnt     <= sat_inc(cnt);
            if (cnt == CNT_MAX) sat <= 1'b1;
            if (in_last) state <= HOLD;
          end
        end
        HOLD: begin
          // Release cycle never accepts, so the accumulator starts clean.
          if (out_ready) begin
            state   <= ACCUM;
            lrc_acc <= '0;
            cnt     <= '0;
            sat     <= 1'b0;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

  // Outputs decode only registered state; the partial packet stays hidden in ACCUM.
  assign in_ready   = (state == ACCUM);
  assign out_valid  = (state == HOLD);
  assign out_lrc    = (state == HOLD) ? lrc_acc : '0;
  assign out_count  = (state == HOLD) ? cnt : '0;
  assign out_sat    = (state == HOLD) && sat;
  assign out_parity = (^out_lrc) ^ ODD;

endmodule

// File: tb/tb_parity_accumulator.sv
// Randomised plus directed bench for parity_accumulator: three configurations
// share one stimulus stream and are compared against a packet-level model.
module tb_parity_accumulator;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_last = 1'b0;
  logic       out_ready = 1'b0;

  logic       a_in_ready, a_out_valid, a_parity, a_sat;
  logic [7:0] a_lrc, a_count;
  logic       b_in_ready, b_out_valid, b_parity, b_sat;
  logic [7:0] b_lrc;
  logic [1:0] b_count;
  logic       c_in_ready, c_out_valid, c_parity, c_sat;
  logic [2:0] c_lrc;
  logic [7:0] c_count;

  always #5 clk = ~clk;

  parity_accumulator #(.W(8), .ODD(1'b1), .CW(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_data(in_data), .in_last(in_last), .out_valid(a_out_valid),
    .out_ready(out_ready), .out_lrc(a_lrc), .out_parity(a_parity),
    .out_count(a_count), .out_sat(a_sat));

  parity_accumulator #(.W(8), .ODD(1'b0), .CW(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_data(in_data), .in_last(in_last), .out_valid(b_out_valid),
    .out_ready(out_ready), .out_lrc(b_lrc), .out_parity(b_parity),
    .out_count(b_count), .out_sat(b_sat));

  parity_accumulator #(.W(3), .ODD(1'b0), .CW(8)) dut_c (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(c_in_ready),
    .in_data(in_data[2:0]), .in_last(in_last), .out_valid(c_out_valid),
    .out_ready(out_ready), .out_lrc(c_lrc), .out_parity(c_parity),
    .out_count(c_count), .out_sat(c_sat));

  int n_checks = 0;
  int n_errors = 0;

  // Packet-level model: words accepted so far and the presented result.
  logic [7:0] words[$];
  bit         exp_hold = 1'b0;
  logic [7:0] exp_lrc = 8'h00;
  int         exp_n = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic compare_all();
    logic [7:0] l8;
    logic [2:0] l3;
    int ca, cb;
    bit sa, sb;
    l8 = exp_hold ? exp_lrc : 8'h00;
    l3 = l8[2:0];
    ca = exp_hold ? ((exp_n > 255) ? 255 : exp_n) : 0;
    cb = exp_hold ? ((exp_n > 3) ? 3 : exp_n) : 0;
    sa = exp_hold && (exp_n > 255);
    sb = exp_hold && (exp_n > 3);
    check_eq("a_in_ready", 32'(a_in_ready), 32'(!exp_hold));
    check_eq("a_out_valid", 32'(a_out_valid), 32'(exp_hold));
    check_eq("a_lrc", 32'(a_lrc), 32'(l8));
    check_eq("a_parity", 32'(a_parity), 32'((^l8) ^ 1'b1));
    check_eq("a_count", 32'(a_count), 32'(ca));
    check_eq("a_sat", 32'(a_sat), 32'(sa));
    check_eq("b_in_ready", 32'(b_in_ready), 32'(!exp_hold));
    check_eq("b_out_valid", 32'(b_out_valid), 32'(exp_hold));
    check_eq("b_lrc", 32'(b_lrc), 32'(l8));
    check_eq("b_parity", 32'(b_parity), 32'(^l8));
    check_eq("b_count", 32'(b_count), 32'(cb));
    check_eq("b_sat", 32'(b_sat), 32'(sb));
    check_eq("c_in_ready", 32'(c_in_ready), 32'(!exp_hold));
    check_eq("c_out_valid", 32'(c_out_valid), 32'(exp_hold));
    check_eq("c_lrc", 32'(c_lrc), 32'(l3));
    check_eq("c_parity", 32'(c_parity), 32'(^l3));
    check_eq("c_count", 32'(c_count), 32'(ca));
    check_eq("c_sat", 32'(c_sat), 32'(sa));
  endtask

  // Called just after a rising edge: drive, check at the falling edge, advance model.
  task automatic step(input bit v, input logic [7:0] d, input bit l, input bit r);
    in_valid  = v;
    in_data   = d;
    in_last   = l;
    out_ready = r;
    @(negedge clk);
    compare_all();
    @(posedge clk);
    if (!exp_hold) begin
      if (v) begin
        words.push_back(d);
        if (l) begin
          exp_lrc = 8'h00;
          foreach (words[i]) exp_lrc ^= words[i];
          exp_n    = words.size();
          exp_hold = 1'b1;
        end
      end
    end else if (r) begin
      exp_hold = 1'b0;
      words.delete();
    end
    #1;
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    #2;
    words.delete();
    exp_hold = 1'b0;
    compare_all();
    check_eq("rst_a_parity_is_odd", 32'(a_parity), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  logic [7:0] pkt[4];
  bit         par3[8];
  logic [7:0] rnd;

  initial begin
    pkt  = '{8'h01, 8'h02, 8'h04, 8'h80};
    par3 = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    #1;
    do_reset();

    // Single-word packets on the 3-bit instance.
    for (int i = 0; i < 8; i++) begin
      rnd = 8'(i);
      step(1'b1, rnd, 1'b1, 1'b1);
      check_eq("w3_parity", 32'(c_parity), 32'(par3[i]));
      check_eq("w3_count", 32'(c_count), 32'd1);
      check_eq("w3_lrc", 32'(c_lrc), 32'(i));
      step(1'b0, 8'h00, 1'b0, 1'b1);
    end

    // Four-word packet, then backpressure for five cycles.
    for (int i = 0; i < 4; i++) step(1'b1, pkt[i], i == 3, 1'b0);
    check_eq("pkt_lrc", 32'(a_lrc), 32'h87);
    check_eq("pkt_parity", 32'(a_parity), 32'd1);
    check_eq("pkt_count", 32'(a_count), 32'd4);
    check_eq("pkt_b_count_sat", 32'(b_count), 32'd3);
    check_eq("pkt_b_sat", 32'(b_sat), 32'd1);
    for (int i = 0; i < 5; i++) begin
      rnd = 8'($urandom);
      step(1'b1, rnd, 1'b1, 1'b0);
      check_eq("bp_in_ready", 32'(a_in_ready), 32'd0);
      check_eq("bp_lrc", 32'(a_lrc), 32'h87);
      check_eq("bp_count", 32'(a_count), 32'd4);
    end
    step(1'b0, 8'h00, 1'b0, 1'b1);
    check_eq("rel_in_ready", 32'(a_in_ready), 32'd1);
    check_eq("rel_count", 32'(a_count), 32'd0);

    // Five 0xFF words saturate the 2-bit counter.
    for (int i = 0; i < 5; i++) step(1'b1, 8'hFF, i == 4, 1'b0);
    check_eq("sat_b_count", 32'(b_count), 32'd3);
    check_eq("sat_b_sat", 32'(b_sat), 32'd1);
    check_eq("sat_b_lrc", 32'(b_lrc), 32'hFF);
    check_eq("sat_a_count", 32'(a_count), 32'd5);
    step(1'b0, 8'h00, 1'b0, 1'b1);

    // Same four-word packet with idle gaps carrying junk.
    for (int i = 0; i < 4; i++) begin
      rnd = 8'($urandom);
      step(1'b0, rnd, rnd[0], 1'b1);
      step(1'b1, pkt[i], i == 3, 1'b0);
    end
    check_eq("gap_lrc", 32'(a_lrc), 32'h87);
    check_eq("gap_count", 32'(a_count), 32'd4);
    step(1'b0, 8'h00, 1'b0, 1'b1);

    // Reset mid-packet, then a fresh single word.
    step(1'b1, 8'h11, 1'b0, 1'b1);
    step(1'b1, 8'h22, 1'b0, 1'b1);
    do_reset();
    step(1'b1, 8'h5A, 1'b1, 1'b0);
    check_eq("mid_rst_lrc", 32'(a_lrc), 32'h5A);
    check_eq("mid_rst_count", 32'(a_count), 32'd1);

    // Reset while holding discards the pending result.
    do_reset();
    check_eq("hold_rst_valid", 32'(a_out_valid), 32'd0);
    step(1'b0, 8'h00, 1'b0, 1'b1);

    // Long packet to saturate the 8-bit counter.
    for (int i = 0; i < 300; i++) begin
      rnd = 8'($urandom);
      step(1'b1, rnd, i == 299, 1'b0);
    end
    check_eq("long_count", 32'(a_count), 32'd255);
    check_eq("long_sat", 32'(a_sat), 32'd1);
    step(1'b0, 8'h00, 1'b0, 1'b1);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      rnd = 8'($urandom);
      step(($urandom % 4) != 0, rnd, ($urandom % 5) == 0, ($urandom % 3) != 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
